mem_port_arbiter: RTL and testbench

Sequential arbiter that shares the single-ported data/instruction SRAM between the instruction-fetch requester and the memory-stage requester. It holds one outstanding transaction at a time and drives the SRAM with registered, stable signals until the SRAM acknowledges. It returns read data with a one-cycle completion pulse and generates per-requester stalls. Sits between the fetch/mem pipeline stages and the SRAM interface.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported SRAM between instruction fetch and the memory stage.
// Holds one transaction at a time, drives the SRAM from registers and pulses completion.
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic        inst_rvalid_o,
    output logic [31:0] inst_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_sel_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        ram_en_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    output logic [3:0]  ram_sel_o,
    input  logic        ram_ack_i,
    input  logic [31:0] ram_rdata_i,

    output logic        stall_if_o,
    output logic        stall_mem_o
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [3:0]  ram_sel_q, ram_sel_d;
    logic        inst_rvalid_q, inst_rvalid_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic        data_rvalid_q, data_rvalid_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic inst_elig, data_elig, burst_hit;

    // A requester in its completion cycle is masked so it cannot be re-granted on stale inputs.
    assign inst_elig = inst_req_i & ~inst_rvalid_q;
    assign data_elig = data_req_i & ~data_rvalid_q;
    assign burst_hit = (streak_q == 4'(MAX_DATA_BURST));

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        ram_we_d      = ram_we_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        ram_sel_d     = ram_sel_q;
        inst_rvalid_d = 1'b0;
        inst_rdata_d  = inst_rdata_q;
        data_rvalid_d = 1'b0;
        data_rdata_d  = data_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (inst_elig && (!data_elig || burst_hit)) begin
                    state_d     = StBusyI;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = inst_addr_i;
                    ram_wdata_d = '0;
                    ram_sel_d   = 4'b1111;
                    streak_d    = '0;
                end else if (data_elig) begin
                    state_d     = StBusyD;
                    ram_we_d    = data_we_i;
                    ram_addr_d  = data_addr_i;
                    ram_wdata_d = data_wdata_i;
                    ram_sel_d   = data_sel_i;
                    // Only count data grants that actually made a fetch wait.
                    if (inst_elig) begin
                        streak_d = (streak_q == 4'd15) ? streak_q : streak_q + 4'd1;
                    end else begin
                        streak_d = '0;
                    end
                end
            end
            StBusyI: begin
                if (ram_ack_i) begin
                    state_d       = StIdle;
                    inst_rvalid_d = 1'b1;
                    inst_rdata_d  = ram_rdata_i;
                end
            end
            StBusyD: begin
                if (ram_ack_i) begin
                    state_d       = StIdle;
                    data_rvalid_d = 1'b1;
                    data_rdata_d  = ram_we_q ? 32'h0 : ram_rdata_i;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            streak_q      <= '0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            ram_sel_q     <= '0;
            inst_rvalid_q <= 1'b0;
            inst_rdata_q  <= '0;
            data_rvalid_q <= 1'b0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_sel_q     <= ram_sel_d;
            inst_rvalid_q <= inst_rvalid_d;
            inst_rdata_q  <= inst_rdata_d;
            data_rvalid_q <= data_rvalid_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign ram_en_o      = (state_q != StIdle);
    assign ram_we_o      = ram_we_q;
    assign ram_addr_o    = ram_addr_q;
    assign ram_wdata_o   = ram_wdata_q;
    assign ram_sel_o     = ram_sel_q;
    assign inst_rvalid_o = inst_rvalid_q;
    assign inst_rdata_o  = inst_rdata_q;
    assign data_rvalid_o = data_rvalid_q;
    assign data_rdata_o  = data_rdata_q;
    assign stall_if_o    = inst_req_i & ~inst_rvalid_q;
    assign stall_mem_o   = data_req_i & ~data_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard queues and
// hand-written sequences for arbitration order, burst limiting and reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_i, inst_rvalid_o;
    logic [31:0] inst_addr_i, inst_rdata_o;
    logic        data_req_i, data_we_i, data_rvalid_o;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic [3:0]  data_sel_i;
    logic        ram_en_o, ram_we_o, ram_ack_i;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
    logic [3:0]  ram_sel_o;
    logic        stall_if_o, stall_mem_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DATA_BURST(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req_i    (inst_req_i),
        .inst_addr_i   (inst_addr_i),
        .inst_rvalid_o (inst_rvalid_o),
        .inst_rdata_o  (inst_rdata_o),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_sel_i    (data_sel_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .ram_en_o      (ram_en_o),
        .ram_we_o      (ram_we_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_sel_o     (ram_sel_o),
        .ram_ack_i     (ram_ack_i),
        .ram_rdata_i   (ram_rdata_i),
        .stall_if_o    (stall_if_o),
        .stall_mem_o   (stall_mem_o)
    );

    // SRAM model: acks after cur_waits wait cycles; data fixed or derived from address.
    int unsigned cur_waits = 0;
    int unsigned en_cnt;
    logic        use_fixed = 1'b1;
    logic [31:0] cur_rdata = '0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) en_cnt <= 0;
        else if (!ram_en_o || ram_ack_i) en_cnt <= 0;
        else en_cnt <= en_cnt + 1;
    end

    assign ram_ack_i   = ram_en_o && (en_cnt == cur_waits);
    assign ram_rdata_i = use_fixed ? cur_rdata : mem_f(ram_addr_o);

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected rdata pushed at request time, popped on each rvalid pulse.
    logic [31:0] inst_q[$];
    logic [31:0] data_q[$];

    always @(negedge clk) begin
        if (rst && inst_rvalid_o) begin
            if (inst_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL inst_unexpected_rvalid: got rdata %h, expected no pulse", inst_rdata_o);
            end else begin
                check("sb_inst_rdata", inst_rdata_o, inst_q.pop_front());
            end
        end
        if (rst && data_rvalid_o) begin
            if (data_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL data_unexpected_rvalid: got rdata %h, expected no pulse", data_rdata_o);
            end else begin
                check("sb_data_rdata", data_rdata_o, data_q.pop_front());
            end
        end
    end

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int unsigned waits;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0] exp_sel;
        logic       exp_we;
        @(negedge clk);
        use_fixed = 1'b1;
        cur_rdata = v.rdata;
        cur_waits = v.waits;
        exp_sel   = v.is_data ? v.sel : 4'b1111;
        exp_we    = v.is_data ? v.we : 1'b0;
        if (v.is_data) begin
            data_req_i   = 1'b1;
            data_we_i    = v.we;
            data_addr_i  = v.addr;
            data_wdata_i = v.wdata;
            data_sel_i   = v.sel;
            inst_addr_i  = 32'hFFFF_FFFC;
            data_q.push_back(v.exp_rdata);
        end else begin
            inst_req_i   = 1'b1;
            inst_addr_i  = v.addr;
            data_we_i    = 1'b1;
            data_sel_i   = 4'b0000;
            data_wdata_i = 32'hBAD0_BAD0;
            inst_q.push_back(v.exp_rdata);
        end
        #1;
        check($sformatf("v%0d_stall_req", idx), v.is_data ? stall_mem_o : stall_if_o, 1);
        for (int j = 0; j <= int'(v.waits); j++) begin
            @(negedge clk);
            check($sformatf("v%0d_ram_en_c%0d", idx, j), ram_en_o, 1);
            check($sformatf("v%0d_ram_addr_c%0d", idx, j), ram_addr_o, v.addr);
            check($sformatf("v%0d_ram_we_c%0d", idx, j), ram_we_o, exp_we);
            check($sformatf("v%0d_ram_sel_c%0d", idx, j), ram_sel_o, exp_sel);
            if (v.is_data) check($sformatf("v%0d_ram_wdata_c%0d", idx, j), ram_wdata_o, v.wdata);
            check($sformatf("v%0d_stall_c%0d", idx, j), v.is_data ? stall_mem_o : stall_if_o, 1);
            check($sformatf("v%0d_rvalid_early_c%0d", idx, j),
                  v.is_data ? data_rvalid_o : inst_rvalid_o, 0);
        end
        @(negedge clk);
        check($sformatf("v%0d_rvalid", idx), v.is_data ? data_rvalid_o : inst_rvalid_o, 1);
        check($sformatf("v%0d_ram_en_done", idx), ram_en_o, 0);
        check($sformatf("v%0d_stall_done", idx), v.is_data ? stall_mem_o : stall_if_o, 0);
        data_req_i = 1'b0;
        inst_req_i = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_rvalid_pulse", idx), v.is_data ? data_rvalid_o : inst_rvalid_o, 0);
        check($sformatf("v%0d_rdata_hold", idx), v.is_data ? data_rdata_o : inst_rdata_o,
              v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got[6];
        logic        exp_seq[6];
        int          grants;
        logic        prev_en, inst_done;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2002, 32'h1234_1234, 4'b0011, 3, 32'hCAFE_F00D, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0000_0013, 32'h0000_0013};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_3001, 32'h0, 4'b0100, 1, 32'h89AB_CDEF, 32'h89AB_CDEF};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_4003, 32'h7777_7777, 4'b1000, 0, 32'h5555_AAAA, 32'h0};

        rst = 1'b0;
        inst_req_i = 1'b0; inst_addr_i = '0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_wdata_i = '0; data_sel_i = '0;

        // Reset state, and stalls following their equations while in reset.
        repeat (2) @(negedge clk);
        check("rst_ram_en", ram_en_o, 0);
        check("rst_ram_addr", ram_addr_o, 0);
        check("rst_ram_sel", ram_sel_o, 0);
        check("rst_inst_rdata", inst_rdata_o, 0);
        check("rst_data_rvalid", data_rvalid_o, 0);
        data_req_i = 1'b1;
        #1 check("rst_stall_mem", stall_mem_o, 1);
        inst_req_i = 1'b1;
        #1 check("rst_stall_if", stall_if_o, 1);
        data_req_i = 1'b0;
        inst_req_i = 1'b0;
        #1 check("rst_stall_idle", {stall_if_o, stall_mem_o}, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Simultaneous requests: data first, fetch taken in the data completion cycle.
        @(negedge clk);
        use_fixed = 1'b0;
        cur_waits = 0;
        inst_req_i = 1'b1; inst_addr_i = 32'h0000_0400;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_1000; data_sel_i = 4'hF;
        data_q.push_back(mem_f(32'h0000_1000));
        inst_q.push_back(mem_f(32'h0000_0400));
        @(negedge clk);
        check("sim_n1_ram_en", ram_en_o, 1);
        check("sim_n1_ram_addr", ram_addr_o, 32'h0000_1000);
        check("sim_n1_stall_if", stall_if_o, 1);
        @(negedge clk);
        check("sim_n2_data_rvalid", data_rvalid_o, 1);
        check("sim_n2_ram_en", ram_en_o, 0);
        data_req_i = 1'b0;
        @(negedge clk);
        check("sim_n3_ram_en", ram_en_o, 1);
        check("sim_n3_ram_addr", ram_addr_o, 32'h0000_0400);
        check("sim_n3_ram_sel", ram_sel_o, 4'hF);
        check("sim_n3_inst_rvalid", inst_rvalid_o, 0);
        @(negedge clk);
        check("sim_n4_inst_rvalid", inst_rvalid_o, 1);
        check("sim_n4_stall_if", stall_if_o, 0);
        inst_req_i = 1'b0;
        @(negedge clk);

        // Burst limit: fetch withdraws only in data completion cycles, so each data grant
        // is made while it waits; after 4 such grants the fetch must win.
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        grants = 0; prev_en = 1'b0; inst_done = 1'b0;
        cur_waits = 0;
        inst_addr_i = 32'h0000_0100;
        data_addr_i = 32'h0000_2000; data_we_i = 1'b0; data_sel_i = 4'hF;
        data_req_i = 1'b1;
        inst_req_i = 1'b1;
        for (int c = 0; c < 80 && grants < 6; c++) begin
            @(negedge clk);
            if (inst_rvalid_o) inst_done = 1'b1;
            if (ram_en_o && !prev_en) begin
                got[grants] = (ram_addr_o == 32'h0000_0100);
                if (got[grants]) inst_q.push_back(mem_f(32'h0000_0100));
                else data_q.push_back(mem_f(32'h0000_2000));
                grants++;
            end
            prev_en = ram_en_o;
            inst_req_i = !inst_done && !data_rvalid_o;
        end
        check("burst_grant_count", grants, 6);
        for (int i = 0; i < grants; i++) check($sformatf("burst_grant%0d_is_fetch", i), got[i], exp_seq[i]);
        @(negedge clk);
        check("burst_last_data_rvalid", data_rvalid_o, 1);
        data_req_i = 1'b0;
        inst_req_i = 1'b0;
        @(negedge clk);

        // Reset during a fetch with wait states: abandoned, no pulse afterwards.
        @(negedge clk);
        use_fixed = 1'b1; cur_rdata = 32'h0BAD_F00D; cur_waits = 6;
        inst_req_i = 1'b1; inst_addr_i = 32'h0000_0200;
        inst_q.push_back(32'h0BAD_F00D);
        @(negedge clk);
        check("rmid_ram_en_busy", ram_en_o, 1);
        @(negedge clk);
        rst = 1'b0;
        inst_req_i = 1'b0;
        inst_q.delete();
        #1;
        check("rmid_ram_en_drop", ram_en_o, 0);
        check("rmid_ram_addr", ram_addr_o, 0);
        check("rmid_inst_rdata", inst_rdata_o, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check($sformatf("rpost_ram_en_c%0d", j), ram_en_o, 0);
            check($sformatf("rpost_inst_rvalid_c%0d", j), inst_rvalid_o, 0);
        end
        check("rpost_outputs", {ram_we_o, ram_sel_o, data_rvalid_o, stall_if_o, stall_mem_o}, 0);
        check("rpost_ram_wdata", ram_wdata_o, 0);
        check("rpost_data_rdata", data_rdata_o, 0);
        check("rpost_inst_rdata", inst_rdata_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
